// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the round-robin process scheduler:
//   - scheduler FSM state encoding (IDLE, RUN, REQ)
//   - watchdog limit for an unacknowledged switch request
//   - helper deriving the process-id width from the slot count
// Optional feature macro used by the scheduler: SCHED_WATCHDOG_EN
// ---------------------------------------------------------------------------
package sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_REQ  = 2'd2;

    // Cycles a switch request may stay unacknowledged before giving up
    localparam logic [7:0] WDOG_LIMIT = 8'd255;

    // Width of a process id for a given number of slots (at least one bit)
    function automatic int pid_width(input int nproc);
        return (nproc > 1) ? $clog2(nproc) : 1;
    endfunction

endpackage

// File: rtl/proc_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational masked round-robin find-first.
// Scans slots start+1 .. start+NPROC-1 (modulo NPROC) and returns the first
// set bit of mask; when include_start is high the scan begins at start itself.
// Ports:
//   mask          in  NPROC  candidate flags
//   start         in  PID_W  scan origin
//   include_start in  1      also consider the origin slot (checked first)
//   found         out 1      a candidate exists
//   pid           out PID_W  first candidate (0 when none)
// NPROC must be a power of two so the index wraps by truncation.
// ---------------------------------------------------------------------------
module rr_pick
    import sched_pkg::*;
#(
    parameter int NPROC = 8,
    parameter int PID_W = pid_width(NPROC)
) (
    input  logic [NPROC-1:0] mask,
    input  logic [PID_W-1:0] start,
    input  logic             include_start,
    output logic             found,
    output logic [PID_W-1:0] pid
);

    logic [PID_W-1:0] idx_s;
    logic             hit_s;

    // Walk offsets from farthest to nearest so the nearest hit is kept last
    always_comb begin
        found = 1'b0;
        pid   = {PID_W{1'b0}};
        idx_s = {PID_W{1'b0}};
        hit_s = 1'b0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            idx_s = start + PID_W'(i);
            hit_s = mask[idx_s] && ((i != 0) || include_start);
            found = found | hit_s;
            pid   = hit_s ? idx_s : pid;
        end
    end

endmodule

// File: rtl/proc_scheduler.sv
// ---------------------------------------------------------------------------
// proc_scheduler
// Round-robin, quantum-based preemptive scheduler. Holds the process table
// (active flag + saved PC per slot), counts retired user instructions of the
// running process and requests a switch to the next active process when the
// quantum expires or the running process is killed.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   quantum                 instructions per slice, 0 disables preemption
//   tick                    one instruction retired this cycle
//   kernel_mode             pauses quantum counting
//   create_valid/pid/pc     activate a slot with a start PC
//   kill_valid/pid          deactivate a slot (wins over a same-slot create)
//   save_valid/save_pc      store the PC of the current process
//   preempt_req             level switch request, held until preempt_ack
//   preempt_ack             pulse: core has switched to next_pid
//   next_pid/next_pc        switch target and its PC (valid with preempt_req)
//   cur_pid                 running process
//   active_mask             slot active flags
//   idle                    no active process
//   ack_timeout             (SCHED_WATCHDOG_EN only) sticky: request abandoned
// Optional feature macro: SCHED_WATCHDOG_EN
// ---------------------------------------------------------------------------
module proc_scheduler
    import sched_pkg::*;
#(
    parameter int NPROC     = 8,
    parameter int PC_W      = 10,
    parameter int QUANTUM_W = 8,
    parameter int PID_W     = pid_width(NPROC)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [QUANTUM_W-1:0] quantum,
    input  logic                 tick,
    input  logic                 kernel_mode,
    input  logic                 create_valid,
    input  logic [PID_W-1:0]     create_pid,
    input  logic [PC_W-1:0]      create_pc,
    input  logic                 kill_valid,
    input  logic [PID_W-1:0]     kill_pid,
    input  logic                 save_valid,
    input  logic [PC_W-1:0]      save_pc,
    output logic                 preempt_req,
    input  logic                 preempt_ack,
    output logic [PID_W-1:0]     next_pid,
    output logic [PC_W-1:0]      next_pc,
    output logic [PID_W-1:0]     cur_pid,
    output logic [NPROC-1:0]     active_mask,
    output logic                 idle
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic                 ack_timeout
`endif
);

    state_t               state_r, state_nxt_s;
    logic [PID_W-1:0]     cur_pid_r, cur_pid_nxt_s;
    logic [QUANTUM_W-1:0] cnt_r, cnt_nxt_s;
    logic                 from_idle_r, from_idle_nxt_s;
    logic [NPROC-1:0]     active_r, active_nxt_s;
    logic [PC_W-1:0]      pc_table_r [NPROC];
    logic [PC_W-1:0]      pc_nxt_s   [NPROC];
    logic                 preempt_req_r;
    logic                 idle_r;

    logic                 pick_incl_s;
    logic                 pick_found_s;
    logic [PID_W-1:0]     pick_pid_s;
    logic                 count_tick_s;
    logic                 expire_s;
    logic                 cur_gone_s;
    logic                 wd_fire_s;

    // A request raised from IDLE has no running process yet, so the current
    // slot itself is a legal target; otherwise the running slot is skipped.
    assign pick_incl_s = (state_r == ST_IDLE) ||
                         ((state_r == ST_REQ) && from_idle_r);

    rr_pick #(
        .NPROC (NPROC),
        .PID_W (PID_W)
    ) u_rr_pick (
        .mask          (active_r),
        .start         (cur_pid_r),
        .include_start (pick_incl_s),
        .found         (pick_found_s),
        .pid           (pick_pid_s)
    );

    assign count_tick_s = tick && !kernel_mode;
    assign expire_s     = count_tick_s && (quantum != {QUANTUM_W{1'b0}}) &&
                          (cnt_r == (quantum - QUANTUM_W'(1)));
    // Also covers a target killed in the same cycle it was acknowledged
    assign cur_gone_s   = (kill_valid && (kill_pid == cur_pid_r)) ||
                          !active_r[cur_pid_r];

`ifdef SCHED_WATCHDOG_EN
    logic [7:0] wd_cnt_r;
    logic       ack_timeout_r;
    logic       timeout_s;

    assign wd_fire_s = (state_r == ST_REQ) && (wd_cnt_r == (WDOG_LIMIT - 8'd1));
    assign timeout_s = wd_fire_s && pick_found_s && !preempt_ack;

    // Watchdog: counts cycles spent waiting in REQ, latches a sticky timeout
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_r      <= 8'd0;
            ack_timeout_r <= 1'b0;
        end else begin
            wd_cnt_r      <= ((state_r == ST_REQ) && (state_nxt_s == ST_REQ)) ?
                             (wd_cnt_r + 8'd1) : 8'd0;
            ack_timeout_r <= ack_timeout_r | timeout_s;
        end
    end

    assign ack_timeout = ack_timeout_r;
`else
    assign wd_fire_s = 1'b0;
`endif

    // Next-state, next-process and quantum counter decisions
    always_comb begin
        state_nxt_s     = state_r;
        cur_pid_nxt_s   = cur_pid_r;
        cnt_nxt_s       = cnt_r;
        from_idle_nxt_s = from_idle_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = {QUANTUM_W{1'b0}};
                if (active_r != {NPROC{1'b0}}) begin
                    state_nxt_s     = ST_REQ;
                    from_idle_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cur_gone_s) begin
                    cnt_nxt_s       = {QUANTUM_W{1'b0}};
                    from_idle_nxt_s = 1'b0;
                    state_nxt_s     = pick_found_s ? ST_REQ : ST_IDLE;
                end else if (expire_s) begin
                    // With no other process the slice simply restarts
                    cnt_nxt_s       = {QUANTUM_W{1'b0}};
                    from_idle_nxt_s = 1'b0;
                    state_nxt_s     = pick_found_s ? ST_REQ : ST_RUN;
                end else if (count_tick_s) begin
                    cnt_nxt_s = cnt_r + QUANTUM_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_REQ: begin
                cnt_nxt_s = {QUANTUM_W{1'b0}};
                if (!pick_found_s) begin
                    state_nxt_s = active_r[cur_pid_r] ? ST_RUN : ST_IDLE;
                end else if (preempt_ack) begin
                    cur_pid_nxt_s = pick_pid_s;
                    state_nxt_s   = ST_RUN;
                end else if (wd_fire_s) begin
                    state_nxt_s = active_r[cur_pid_r] ? ST_RUN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {QUANTUM_W{1'b0}};
            end
        endcase
    end

    // Process table next values: kill beats create, create beats save
    always_comb begin
        for (int p = 0; p < NPROC; p++) begin
            active_nxt_s[p] = (kill_valid && (kill_pid == PID_W'(p))) ? 1'b0 :
                              (create_valid && (create_pid == PID_W'(p))) ? 1'b1 :
                              active_r[p];
            pc_nxt_s[p]     = (create_valid && (create_pid == PID_W'(p)) &&
                               !(kill_valid && (kill_pid == PID_W'(p)))) ? create_pc :
                              (save_valid && (cur_pid_r == PID_W'(p))) ? save_pc :
                              pc_table_r[p];
        end
    end

    // FSM, counter and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cur_pid_r     <= {PID_W{1'b0}};
            cnt_r         <= {QUANTUM_W{1'b0}};
            from_idle_r   <= 1'b0;
            active_r      <= {NPROC{1'b0}};
            preempt_req_r <= 1'b0;
            idle_r        <= 1'b1;
        end else begin
            state_r       <= state_nxt_s;
            cur_pid_r     <= cur_pid_nxt_s;
            cnt_r         <= cnt_nxt_s;
            from_idle_r   <= from_idle_nxt_s;
            active_r      <= active_nxt_s;
            preempt_req_r <= (state_nxt_s == ST_REQ);
            idle_r        <= (active_nxt_s == {NPROC{1'b0}});
        end
    end

    // Saved-PC table
    always_ff @(posedge clock) begin
        for (int p = 0; p < NPROC; p++) begin
            pc_table_r[p] <= reset ? {PC_W{1'b0}} : pc_nxt_s[p];
        end
    end

    assign preempt_req = preempt_req_r;
    assign cur_pid     = cur_pid_r;
    assign active_mask = active_r;
    assign idle        = idle_r;
    assign next_pid    = (state_r == ST_REQ) ? pick_pid_s : {PID_W{1'b0}};
    assign next_pc     = (state_r == ST_REQ) ? pc_table_r[pick_pid_s] : {PC_W{1'b0}};

endmodule

// File: tb/tb_proc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_proc_scheduler
// Directed scenarios followed by randomized traffic. A behavioural model of
// the scheduler advances once per cycle alongside the stimulus and pushes the
// expected post-edge outputs into a queue; an independent monitor pops one
// entry per cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_proc_scheduler;

    localparam int NPROC = 8;
    localparam int PID_W = 3;
    localparam int PC_W  = 10;
    localparam int QW    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [QW-1:0]     quantum;
    logic              tick;
    logic              kernel_mode;
    logic              create_valid;
    logic [PID_W-1:0]  create_pid;
    logic [PC_W-1:0]   create_pc;
    logic              kill_valid;
    logic [PID_W-1:0]  kill_pid;
    logic              save_valid;
    logic [PC_W-1:0]   save_pc;
    logic              preempt_ack;
    logic              preempt_req;
    logic [PID_W-1:0]  next_pid;
    logic [PC_W-1:0]   next_pc;
    logic [PID_W-1:0]  cur_pid;
    logic [NPROC-1:0]  active_mask;
    logic              idle;
`ifdef SCHED_WATCHDOG_EN
    logic              ack_timeout;
`endif

    proc_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .quantum      (quantum),
        .tick         (tick),
        .kernel_mode  (kernel_mode),
        .create_valid (create_valid),
        .create_pid   (create_pid),
        .create_pc    (create_pc),
        .kill_valid   (kill_valid),
        .kill_pid     (kill_pid),
        .save_valid   (save_valid),
        .save_pc      (save_pc),
        .preempt_req  (preempt_req),
        .preempt_ack  (preempt_ack),
        .next_pid     (next_pid),
        .next_pc      (next_pc),
        .cur_pid      (cur_pid),
        .active_mask  (active_mask),
        .idle         (idle)
`ifdef SCHED_WATCHDOG_EN
        ,
        .ack_timeout  (ack_timeout)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_REQ} mstate_e;

    mstate_e m_state;
    int      m_cur;
    bit      m_act [NPROC];
    int      m_pc  [NPROC];
    bit      m_running;   // a process has actually been switched in
    int      m_slice;     // counted instructions in the current slice
    int      m_reqcyc;    // cycles already spent waiting for an ack
    bit      m_tmo;

    typedef struct {
        bit req;
        int cur;
        int mask;
        bit idle;
        bit nvalid;
        int npid;
        int npc;
        bit tmo;
    } snap_t;

    snap_t exp_q [$];
    snap_t e;
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_cur     = 0;
        m_running = 1'b0;
        m_slice   = 0;
        m_reqcyc  = 0;
        m_tmo     = 1'b0;
        for (int p = 0; p < NPROC; p++) begin
            m_act[p] = 1'b0;
            m_pc[p]  = 0;
        end
    endfunction

    // First active slot after the current one in round-robin order
    function automatic int pick(bit incl);
        for (int k = (incl ? 0 : 1); k < NPROC; k++) begin
            int p;
            p = (m_cur + k) % NPROC;
            if (m_act[p]) return p;
        end
        return -1;
    endfunction

    function automatic bit any_active();
        for (int p = 0; p < NPROC; p++) if (m_act[p]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mask_of();
        int m;
        m = 0;
        for (int p = 0; p < NPROC; p++) if (m_act[p]) m = m | (1 << p);
        return m;
    endfunction

    function automatic void enter_req();
        m_state  = M_REQ;
        m_reqcyc = 0;
    endfunction

    // Leave a pending request without switching
    function automatic void abandon_req();
        m_slice = 0;
        if (m_act[m_cur]) begin
            m_state   = M_RUN;
            m_running = 1'b1;
        end else begin
            m_state   = M_IDLE;
            m_running = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int old_cur;
        int cand;
        bit kh, ch;
        if (reset) begin
            model_reset();
            return;
        end
        old_cur = m_cur;
        cand    = pick(!m_running);
        case (m_state)
            M_IDLE: if (any_active()) enter_req();
            M_RUN: begin
                if ((kill_valid && int'(kill_pid) == m_cur) || !m_act[m_cur]) begin
                    m_slice = 0;
                    if (cand >= 0) enter_req();
                    else begin
                        m_state   = M_IDLE;
                        m_running = 1'b0;
                    end
                end else if (tick && !kernel_mode) begin
                    if (quantum != 0 && m_slice + 1 == int'(quantum)) begin
                        m_slice = 0;
                        if (cand >= 0) enter_req();
                    end else begin
                        m_slice = (m_slice + 1) % 256;
                    end
                end
            end
            M_REQ: begin
                if (cand < 0) abandon_req();
                else if (preempt_ack) begin
                    m_cur     = cand;
                    m_state   = M_RUN;
                    m_running = 1'b1;
                    m_slice   = 0;
                end
`ifdef SCHED_WATCHDOG_EN
                else if (m_reqcyc + 1 >= 255) begin
                    m_tmo = 1'b1;
                    abandon_req();
                end
`endif
                else m_reqcyc++;
            end
            default: m_state = M_IDLE;
        endcase
        for (int p = 0; p < NPROC; p++) begin
            kh = kill_valid && (int'(kill_pid) == p);
            ch = create_valid && (int'(create_pid) == p);
            if (kh) m_act[p] = 1'b0;
            else if (ch) m_act[p] = 1'b1;
            if (ch && !kh) m_pc[p] = int'(create_pc);
            else if (save_valid && old_cur == p) m_pc[p] = int'(save_pc);
        end
    endfunction

    // Apply the current inputs to the model, queue the expectation, advance
    task automatic step();
        snap_t s;
        int    c;
        model_step();
        c        = pick(!m_running);
        s.req    = (m_state == M_REQ);
        s.cur    = m_cur;
        s.mask   = mask_of();
        s.idle   = !any_active();
        s.nvalid = s.req && (c >= 0);
        s.npid   = (c >= 0) ? c : 0;
        s.npc    = (c >= 0) ? m_pc[c] : 0;
        s.tmo    = m_tmo;
        exp_q.push_back(s);
        @(posedge clock);
        #4;
    endtask

    task automatic clear_pulses();
        tick         = 1'b0;
        create_valid = 1'b0;
        kill_valid   = 1'b0;
        save_valid   = 1'b0;
        preempt_ack  = 1'b0;
    endtask

    task automatic do_create(input int pid, input int pc);
        create_valid = 1'b1;
        create_pid   = PID_W'(pid);
        create_pc    = PC_W'(pc);
        step();
        clear_pulses();
    endtask

    task automatic until_req();
        for (int i = 0; i < 20 && m_state != M_REQ; i++) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic ack_now();
        preempt_ack = 1'b1;
        step();
        clear_pulses();
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("preempt_req", 32'(preempt_req), 32'(e.req));
                check("cur_pid", 32'(cur_pid), e.cur);
                check("active_mask", 32'(active_mask), e.mask);
                check("idle", 32'(idle), 32'(e.idle));
                if (e.nvalid) begin
                    check("next_pid", 32'(next_pid), e.npid);
                    check("next_pc", 32'(next_pc), e.npc);
                end
`ifdef SCHED_WATCHDOG_EN
                check("ack_timeout", 32'(ack_timeout), 32'(e.tmo));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_pulses();
        reset       = 1'b1;
        quantum     = 8'd0;
        kernel_mode = 1'b0;
        create_pid  = 3'd0;
        create_pc   = 10'd0;
        kill_pid    = 3'd0;
        save_pc     = 10'd0;
        model_reset();
        @(posedge clock);
        #4;
        repeat (3) step();
        reset = 1'b0;

        // First process from IDLE
        do_create(0, 10'h040);
        until_req();
        step();
        ack_now();

        // Quantum expiry to pid 3, save at ack lands in pid 0
        quantum = 8'd4;
        do_create(3, 10'h123);
        ticks(4);
        step();
        save_valid  = 1'b1;
        save_pc     = 10'h055;
        ack_now();
        ticks(4);
        step();
        ack_now();

        // Single process never preempted
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_create(2, 10'h200);
        until_req();
        ack_now();
        quantum = 8'd2;
        ticks(10);

        // Kernel mode freezes the slice counter
        quantum = 8'd5;
        do_create(5, 10'h155);
        ticks(2);
        kernel_mode = 1'b1;
        ticks(20);
        kernel_mode = 1'b0;
        ticks(3);
        step();
        ack_now();

        // Target killed while pending; create+kill of the same slot
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_create(3, 10'h033);
        until_req();
        ack_now();
        do_create(5, 10'h0a5);
        do_create(1, 10'h011);
        quantum = 8'd1;
        ticks(1);
        step();
        kill_valid = 1'b1;
        kill_pid   = 3'd5;
        step();
        clear_pulses();
        step();
        create_valid = 1'b1;
        create_pid   = 3'd6;
        create_pc    = 10'h066;
        kill_valid   = 1'b1;
        kill_pid     = 3'd6;
        step();
        clear_pulses();
        step();
        ack_now();

        // Reset while a request is pending
        ticks(1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

`ifdef SCHED_WATCHDOG_EN
        // Unacknowledged request times out
        do_create(0, 10'h010);
        until_req();
        ack_now();
        do_create(4, 10'h044);
        quantum = 8'd1;
        ticks(1);
        repeat (260) step();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clear_pulses();
            if (c % 200 == 0)
                quantum = ($urandom_range(0, 7) == 0) ? 8'd0 : QW'($urandom_range(1, 6));
            if ($urandom_range(0, 19) == 0) kernel_mode = ~kernel_mode;
            tick         = ($urandom_range(0, 9) < 7);
            create_valid = ($urandom_range(0, 9) == 0);
            create_pid   = PID_W'($urandom_range(0, NPROC - 1));
            create_pc    = PC_W'($urandom_range(0, 1023));
            kill_valid   = ($urandom_range(0, 15) == 0);
            kill_pid     = ($urandom_range(0, 3) == 0) ? create_pid :
                           PID_W'($urandom_range(0, NPROC - 1));
            save_valid   = ($urandom_range(0, 7) == 0);
            save_pc      = PC_W'($urandom_range(0, 1023));
            preempt_ack  = (m_state == M_REQ) ? ($urandom_range(0, 3) == 0) :
                                                ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            step();
        end
        clear_pulses();
        reset = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #3;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
